// File: rtl/reg_file_pkg.sv
// Shared register-file parameters and forwarding encodings, used by the register file,
// the operand port muxes and the hazard logic.
package reg_file_pkg;

  localparam int REG_DATA_WIDTH = 16;
  localparam int REG_NUM_WIDTH  = 4;
  localparam int NUM_REGISTERS  = 16;

  // Operand source selects shared by the port muxes and hazard logic.
  typedef enum logic [1:0] {
    REG_FORWARD_NONE = 2'd0,
    REG_FORWARD_WB   = 2'd1,
    REG_FORWARD_R0   = 2'd2
  } reg_forward_e;

  function automatic logic reg_num_valid(input int unsigned num, input int unsigned num_regs);
    return num < num_regs;
  endfunction

endpackage

// File: rtl/reg_file.sv
// General-purpose register file: two combinational read ports, one write-back port,
// a dedicated R0 write port and a registered illegal-write-number pulse.
module reg_file #(
  parameter int REG_DATA_WIDTH = reg_file_pkg::REG_DATA_WIDTH,
  parameter int REG_NUM_WIDTH  = reg_file_pkg::REG_NUM_WIDTH,
  parameter int NUM_REGISTERS  = reg_file_pkg::NUM_REGISTERS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_NUM_WIDTH-1:0]  rna,
  input  logic [REG_NUM_WIDTH-1:0]  rnb,
  output logic [REG_DATA_WIDTH-1:0] rfile_data_a,
  output logic [REG_DATA_WIDTH-1:0] rfile_data_b,
  input  logic                      wr_en,
  input  logic [REG_NUM_WIDTH-1:0]  wrn,
  input  logic [REG_DATA_WIDTH-1:0] wrd,
  input  logic                      r0_wr_en,
  input  logic [REG_DATA_WIDTH-1:0] r0_wrd,
  output logic [REG_DATA_WIDTH-1:0] r0d,
  output logic                      wr_exception
);
  import reg_file_pkg::*;

  logic [REG_DATA_WIDTH-1:0] rd_view [NUM_REGISTERS];
  logic                      wrn_valid;
  logic                      wr_exception_d;
  logic                      wr_exception_q;

  assign wrn_valid = reg_num_valid(32'(wrn), NUM_REGISTERS);

  for (genvar gi = 0; gi < NUM_REGISTERS; gi++) begin : g_reg
    logic [REG_DATA_WIDTH-1:0] reg_d;
    logic [REG_DATA_WIDTH-1:0] reg_q;

    // The R0 port is applied last so it overrides a write-back aimed at R0.
    always_comb begin
      reg_d = reg_q;
      if (wr_en && (wrn == REG_NUM_WIDTH'(gi))) begin
        reg_d = wrd;
      end
      if ((gi == 0) && r0_wr_en) begin
        reg_d = r0_wrd;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rd_view[gi] = reg_q;
  end

  always_comb begin
    wr_exception_d = wr_en && !wrn_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_exception_q <= 1'b0;
    end else begin
      wr_exception_q <= wr_exception_d;
    end
  end

  // Unimplemented register numbers fall through to zero; the port mux flags them.
  always_comb begin
    rfile_data_a = '0;
    rfile_data_b = '0;
    for (int i = 0; i < NUM_REGISTERS; i++) begin
      if (rna == REG_NUM_WIDTH'(i)) rfile_data_a = rd_view[i];
      if (rnb == REG_NUM_WIDTH'(i)) rfile_data_b = rd_view[i];
    end
  end

  assign r0d          = rd_view[0];
  assign wr_exception = wr_exception_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench: a full 16-register instance and an 8-register instance share one
// stimulus stream; expected outputs are queued at drive time and popped at sample time.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rna, rnb, wrn;
  logic        wr_en, r0_wr_en;
  logic [15:0] wrd, r0_wrd;

  logic [15:0] a16, b16, r0d16, a8, b8, r0d8;
  logic        exc16, exc8;

  always #5 clk = ~clk;

  reg_file dut16 (
    .clk(clk), .rst_n(rst_n), .rna(rna), .rnb(rnb),
    .rfile_data_a(a16), .rfile_data_b(b16),
    .wr_en(wr_en), .wrn(wrn), .wrd(wrd),
    .r0_wr_en(r0_wr_en), .r0_wrd(r0_wrd),
    .r0d(r0d16), .wr_exception(exc16)
  );

  reg_file #(.NUM_REGISTERS(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .rna(rna), .rnb(rnb),
    .rfile_data_a(a8), .rfile_data_b(b8),
    .wr_en(wr_en), .wrn(wrn), .wrd(wrd),
    .r0_wr_en(r0_wr_en), .r0_wrd(r0_wrd),
    .r0d(r0d8), .wr_exception(exc8)
  );

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] m16 [16];
  logic [15:0] m8  [8];
  logic        exc16_m, exc8_m;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_next(input logic [15:0] got);
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", got, 16'hxxxx);
    end else begin
      e = sb_q.pop_front();
      check(e.tag, got, e.exp);
    end
  endtask

  function automatic logic [15:0] rd16(input logic [3:0] n);
    return m16[n];
  endfunction

  function automatic logic [15:0] rd8(input logic [3:0] n);
    return (n < 4'd8) ? m8[n[2:0]] : 16'h0000;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 16; i++) m16[i] = '0;
    for (int i = 0; i < 8; i++) m8[i] = '0;
    exc16_m = 1'b0;
    exc8_m  = 1'b0;
  endtask

  // One clock: drive just after a falling edge, check combinational outputs, then
  // advance the reference model on the rising edge.
  task automatic cyc(input logic [3:0] a, input logic [3:0] b, input logic we,
                     input logic [3:0] wn, input logic [15:0] wd,
                     input logic r0we, input logic [15:0] r0wd);
    rna = a; rnb = b; wr_en = we; wrn = wn; wrd = wd; r0_wr_en = r0we; r0_wrd = r0wd;
    sb_q.push_back('{"a16", rd16(a)});
    sb_q.push_back('{"b16", rd16(b)});
    sb_q.push_back('{"r0d16", m16[0]});
    sb_q.push_back('{"exc16", {15'd0, exc16_m}});
    sb_q.push_back('{"a8", rd8(a)});
    sb_q.push_back('{"b8", rd8(b)});
    sb_q.push_back('{"r0d8", m8[0]});
    sb_q.push_back('{"exc8", {15'd0, exc8_m}});
    #1;
    check_next(a16); check_next(b16); check_next(r0d16); check_next({15'd0, exc16});
    check_next(a8);  check_next(b8);  check_next(r0d8);  check_next({15'd0, exc8});
    @(posedge clk);
    if (we) m16[wn] = wd;
    if (we && wn < 4'd8) m8[wn[2:0]] = wd;
    if (r0we) begin
      m16[0] = r0wd;
      m8[0]  = r0wd;
    end
    exc16_m = 1'b0;
    exc8_m  = we && (wn >= 4'd8);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_a16"}, a16, 16'h0);
    check({phase, "_b16"}, b16, 16'h0);
    check({phase, "_r0d16"}, r0d16, 16'h0);
    check({phase, "_exc16"}, {15'd0, exc16}, 16'h0);
    check({phase, "_a8"}, a8, 16'h0);
    check({phase, "_b8"}, b8, 16'h0);
    check({phase, "_r0d8"}, r0d8, 16'h0);
    check({phase, "_exc8"}, {15'd0, exc8}, 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    rna = 4'd0; rnb = 4'd0; wr_en = 1'b0; wrn = 4'd0; wrd = '0;
    r0_wr_en = 1'b0; r0_wrd = '0;
    clear_model();
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Read-during-write returns old value, new value visible next cycle.
    cyc(4'd5, 4'd5, 1'b1, 4'd5, 16'hBEEF, 1'b0, 16'h0);
    cyc(4'd5, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    // R0 port beats write-back to R0.
    cyc(4'd0, 4'd5, 1'b1, 4'd0, 16'hFFFF, 1'b1, 16'h1234);
    // Both ports commit when write-back targets another register.
    cyc(4'd0, 4'd3, 1'b1, 4'd3, 16'h0055, 1'b1, 16'h00AA);
    cyc(4'd3, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    // Write number 9: legal for 16 registers, illegal for 8.
    cyc(4'd9, 4'd1, 1'b1, 4'd9, 16'hDEAD, 1'b0, 16'h0);
    cyc(4'd9, 4'd9, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    cyc(4'd9, 4'd1, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    // Back-to-back illegal writes keep the pulse high each following cycle.
    cyc(4'd15, 4'd8, 1'b1, 4'd15, 16'h5A5A, 1'b0, 16'h0);
    cyc(4'd15, 4'd8, 1'b1, 4'd8, 16'hA5A5, 1'b0, 16'h0);
    cyc(4'd15, 4'd8, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    // Same register on both read ports.
    cyc(4'd7, 4'd7, 1'b1, 4'd7, 16'h0707, 1'b0, 16'h0);
    cyc(4'd7, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    // Back-to-back writes to one register.
    cyc(4'd2, 4'd2, 1'b1, 4'd2, 16'h1111, 1'b0, 16'h0);
    cyc(4'd2, 4'd2, 1'b1, 4'd2, 16'h2222, 1'b0, 16'h0);
    cyc(4'd2, 4'd7, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);

    for (int i = 0; i < 40; i++) begin
      cyc(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 3) == 0),
          16'($urandom));
    end

    // Fill a few registers, then reset mid-operation with writes pending.
    cyc(4'd4, 4'd0, 1'b1, 4'd4, 16'hC0DE, 1'b1, 16'h7777);
    rna = 4'd4; rnb = 4'd0; wr_en = 1'b1; wrn = 4'd9; wrd = 16'h9999;
    r0_wr_en = 1'b1; r0_wrd = 16'h4321;
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    @(posedge clk);
    #1;
    check_all_zero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    cyc(4'd4, 4'd9, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);
    cyc(4'd4, 4'd0, 1'b1, 4'd4, 16'h4444, 1'b0, 16'h0);
    cyc(4'd4, 4'd0, 1'b0, 4'd0, 16'h0, 1'b0, 16'h0);

    check("scoreboard_drained", 16'(sb_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
